ofm_writeback_ctrl: RTL

//   Parametrised OFM write-back sequencer between PE-array output and next-layer RAM.

---
 rtl/ofm_writeback_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ofm_writeback_ctrl.sv
// ofm_writeback_ctrl
//   Write-back sequencer between the PE-array OFM outputs and the next-layer
//   RAM. Once every lane reports valid, it walks NUM_GROUPS mux groups and
//   issues one RAM write per group, honouring wr_ready backpressure. The write
//   address wraps inside a window, and completed tiles are counted. A clear
//   request returns the address to BASE_ADDR and zeroes the tile count; if the
//   clear arrives mid-tile, it is deferred until the tile finishes.
//
// Ports
//   clk              in   rising-edge clock
//   rst_n            in   synchronous active-low reset
//   ofm_out_valid    in   per-lane OFM result valid
//   wr_ready         in   RAM accepts a write this cycle
//   clear_addr       in   request address/tile-count clear
//   control_mux      out  group select for the OFM output mux
//   addr_ram_next_wr out  next-layer RAM write address
//   wr_en_next       out  write request (decoded from state)
//   wr_data_valid    out  one-cycle pulse after the last group of a tile
//   busy             out  high while a tile is in flight
//   tile_cnt         out  tiles completed since reset/clear
module ofm_writeback_ctrl #(
  parameter int unsigned NUM_LANES  = 16,
  parameter int unsigned NUM_GROUPS = 4,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned ADDR_DEPTH = 1024,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_LANES-1:0] ofm_out_valid,
  input  logic                 wr_ready,
  input  logic                 clear_addr,
  output logic [SEL_W-1:0]     control_mux,
  output logic [ADDR_W-1:0]    addr_ram_next_wr,
  output logic                 wr_en_next,
  output logic                 wr_data_valid,
  output logic                 busy,
  output logic [CNT_W-1:0]     tile_cnt
);

  localparam logic [ADDR_W-1:0] DEPTH_M1  = ADDR_W'(ADDR_DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = BASE_ADDR + DEPTH_M1;
  localparam logic [SEL_W-1:0]  LAST_GRP  = SEL_W'(NUM_GROUPS - 1);

  typedef enum logic [0:0] {
    S_IDLE,
    S_FETCH
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SEL_W-1:0]    r_mux;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wdv;
  logic [CNT_W-1:0]    r_tile_cnt;
  logic                r_clear_pend;
  logic                w_all_valid;
  logic                w_acc;
  logic                w_last_grp;
  logic                w_clear_now;

  assign w_all_valid = &ofm_out_valid;
  assign w_acc       = wr_en_next & wr_ready;
  assign w_last_grp  = (r_mux == LAST_GRP);
  // Deferred and fresh clears are both applied on an IDLE cycle.
  assign w_clear_now = (r_state == S_IDLE) & (clear_addr | r_clear_pend);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_all_valid) w_state_nxt = S_FETCH;
      S_FETCH: if (w_acc && w_last_grp) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    wr_en_next = 1'b0;
    busy       = 1'b0;
    if (r_state == S_FETCH) begin
      wr_en_next = 1'b1;
      busy       = 1'b1;
    end
  end

  // Datapath: group select, address, tile count, clear bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mux        <= '0;
      r_addr       <= BASE_ADDR;
      r_wdv        <= 1'b0;
      r_tile_cnt   <= '0;
      r_clear_pend <= 1'b0;
    end else begin
      r_wdv <= 1'b0;
      if (w_clear_now) begin
        r_addr       <= BASE_ADDR;
        r_tile_cnt   <= '0;
        r_clear_pend <= 1'b0;
      end
      if (r_state == S_FETCH) begin
        if (clear_addr) begin
          r_clear_pend <= 1'b1;
        end
        if (w_acc) begin
          r_addr <= (r_addr == LAST_ADDR) ? BASE_ADDR : r_addr + ADDR_W'(1);
          if (w_last_grp) begin
            r_mux      <= '0;
            r_wdv      <= 1'b1;
            r_tile_cnt <= r_tile_cnt + CNT_W'(1);
          end else begin
            r_mux <= r_mux + SEL_W'(1);
          end
        end
      end
    end
  end

  assign control_mux      = r_mux;
  assign addr_ram_next_wr = r_addr;
  assign wr_data_valid    = r_wdv;
  assign tile_cnt         = r_tile_cnt;

endmodule
